bcd_serial_add_ctrl: RTL and testbench
======================================

Name: bcd_serial_add_ctrl

Overview:
- Sequencer that adds two DIGITS-digit packed-BCD operands, one digit per clock, by time-sharing a single instance of the team's single-digit BCD adder `bcdadd`.
- `bcdadd` is combinational: ports cin, a[3:0], b[3:0], sum[3:0], cout.
- This block latches operands, steps a digit index LSD→MSD, and registers the ripple carry between digits.
- It raises a done pulse and holds the result until the next start.

Parameters:
- DIGITS, 4, number of BCD digits per operand (legal range 1..16).
- IDX_W, $clog2(DIGITS) (minimum 1), digit index width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_a  in  4*DIGITS  packed BCD operand A, digit 0 at [3:0].
- op_b  in  4*DIGITS  packed BCD operand B.
- cin  in  1  initial carry into digit 0.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result, cout and invalid are final.
- result  out  4*DIGITS  packed BCD sum.
- cout  out  1  carry out of the most significant digit.
- invalid  out  1  some digit of op_a or op_b exceeded 9 when start was sampled.

Behaviour:
- Reset (async assert, any state): state=IDLE; busy=0, done=0, result=0, cout=0, invalid=0; index=0; carry register=0; operand registers=0.
  - Reset mid-RUN aborts the operation. No done pulse is produced.
- State IDLE:
  - start=1 at an edge: latch op_a/op_b into a_q/b_q and cin into carry_q; index=0; result=0; cout=0.
  - Same edge: invalid = OR over all digits of (digit > 9) for op_a and op_b.
  - Go to RUN.
  - start=0: remain in IDLE; all outputs hold.
- State RUN:
  - Each cycle, `bcdadd` sees a=a_q digit[index], b=b_q digit[index], cin=carry_q.
  - At each edge: result digit[index] <= sum; carry_q <= adder cout; index <= index+1.
  - When index==DIGITS-1 at the edge: cout <= adder cout; index <= 0; go to DONE.
- State DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Latency:
  - start accepted at edge T0; digits written at edges T1..TDIGITS; done high in the cycle after edge TDIGITS.
  - A new start can be accepted at edge TDIGITS+2 at the earliest.
- start during RUN or DONE is ignored; it is not queued.
- Changes on op_a/op_b/cin after T0 have no effect on the operation in progress.
- Invalid digits:
  - The operation still runs to completion and the raw `bcdadd` output is written.
  - invalid stays 1 until the next accepted start recomputes it.
- Partial results:
  - result digits update progressively during RUN.
  - Consumers use result/cout only when done=1 or in IDLE after done.
- Index wrap: index never exceeds DIGITS-1. DIGITS=1 gives a one-cycle RUN.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits.
  - localparam BCD_W=4, BCD_MAX=4'd9.
  - function bcd_digit_invalid(d) = (d > 9).
- One sub-module instance: `bcdadd` (existing digit adder), reused unchanged.
- FSM, index counter, carry register and result register live in this block.

Test Plan:
- DIGITS=4, op_a=16'h1234, op_b=16'h5678, cin=0, start pulse → done exactly 5 cycles after the start edge; result=16'h6912, cout=0, invalid=0, busy high for 4 cycles.
- op_a=16'h9999, op_b=16'h0001, cin=0 → result=16'h0000, cout=1. Checks carry ripple through all digits.
- op_a=16'h9999, op_b=16'h9999, cin=1 → result=16'h9999, cout=1. Checks the maximum case.
- Start 16'h0500+16'h0500. Pulse start with different operands during RUN, and change op_a mid-RUN → ignored; result=16'h1000, cout=0, only one done pulse.
- Start 16'h1234+16'h5678, then assert rst_n=0 two cycles later → immediately busy=0, result=0, cout=0, no done. After release, a new start 16'h0001+16'h0002 → result=16'h0003.
- op_a=16'h00A5, op_b=16'h0001 → invalid=1 at the start edge, held through done; next start with 16'h0001+16'h0001 → invalid=0, result=16'h0002.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and helpers for the serial BCD adder
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  // A packed-BCD digit is only legal in 0..9.
  function automatic logic bcd_digit_invalid(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// rtl/bcd_serial_add_ctrl_if.sv - request/response bundle of the serial BCD adder
// master drives start/op_a/op_b/cin and observes busy/done/result/cout/invalid;
// slave (the sequencer) is the reverse.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   op_a;
  logic [4*DIGITS-1:0]   op_b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  cout;
  logic                  invalid;

  modport master (
    output start, op_a, op_b, cin,
    input  busy, done, result, cout, invalid
  );

  modport slave (
    input  start, op_a, op_b, cin,
    output busy, done, result, cout, invalid
  );
endinterface

// File: rtl/bcdadd.sv
// rtl/bcdadd.sv - combinational single-digit BCD adder
// Ports: cin, a[3:0], b[3:0] in; sum[3:0], cout out.
module bcdadd (
  input  logic       cin,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;
  logic [4:0] adj;

  // Binary sum, then the classic +6 correction when it leaves 0..9.
  // Illegal input digits simply pass through the same correction.
  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    adj  = raw + 5'd6;
    sum  = raw[3:0];
    cout = 1'b0;
    if (raw > 5'd9) begin
      sum  = adj[3:0];
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed-BCD adder sequencer
// Ports: clk, rst_n (async active-low), bus (slave modport):
//   start/op_a/op_b/cin request, busy/done/result/cout/invalid response.
// One bcdadd instance is time-shared LSD->MSD, one digit per clock.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_serial_add_ctrl_if.slave    bus
);

  localparam int                 DW       = BCD_W * DIGITS;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [DW-1:0]      a_q, a_d;
  logic [DW-1:0]      b_q, b_d;
  logic [DW-1:0]      result_q, result_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               invalid_q, invalid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [IDX_W+1:0]   bit_off;
  logic [BCD_W-1:0]   dig_a, dig_b, add_sum;
  logic               add_cout;
  logic               inv_any;

  // Bit offset of the current digit (index * 4).
  assign bit_off = {idx_q, 2'b00};
  assign dig_a   = a_q[bit_off +: BCD_W];
  assign dig_b   = b_q[bit_off +: BCD_W];

  bcdadd u_bcdadd (
    .cin  (carry_q),
    .a    (dig_a),
    .b    (dig_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Digit legality is judged on the live inputs, captured only on accept.
  always_comb begin
    inv_any = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      inv_any = inv_any
              | bcd_digit_invalid(bus.op_a[i*BCD_W +: BCD_W])
              | bcd_digit_invalid(bus.op_b[i*BCD_W +: BCD_W]);
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d       = bus.op_a;
          b_d       = bus.op_b;
          carry_d   = bus.cin;
          idx_d     = '0;
          result_d  = '0;
          cout_d    = 1'b0;
          invalid_d = inv_any;
          state_d   = RUN;
        end
      end
      RUN: begin
        result_d[bit_off +: BCD_W] = add_sum;
        carry_d                    = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the upcoming state.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.cout    = cout_q;
  assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - scoreboard bench for the serial BCD adder
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        i;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_seen;
  int   busy_cnt;
  exp_t exp_q[$];

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: on every done pulse pop the oldest expectation and compare.
  // busy must have been high for exactly DIGITS cycles just before done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no done, result=%h", bus.result);
        end else begin
          e = exp_q.pop_front();
          chk("result",   32'(bus.result),  32'(e.r));
          chk("cout",     32'(bus.cout),    32'(e.c));
          chk("invalid",  32'(bus.invalid), 32'(e.i));
          chk("busy_len", 32'(busy_cnt),    32'(DIGITS));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic expect_done,
                       input logic [15:0] er, input logic ec, input logic ei);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    if (expect_done) begin
      e.r = er; e.c = ec; e.i = ei;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n0;
    n0 = done_seen;
    for (int k = 0; k < 40 && done_seen == n0; k++) @(negedge clk);
    if (done_seen == n0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    done_seen = 0;
    busy_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_result",  32'(bus.result),  32'd0);
    chk("rst_cout",    32'(bus.cout),    32'd0);
    chk("rst_invalid", 32'(bus.invalid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0);
    wait_done();
    issue(16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_done();
    issue(16'h9999, 16'h9999, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0);
    wait_done();

    // Start and operand changes during RUN must be ignored.
    issue(16'h0500, 16'h0500, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.op_a  = 16'h1111;
    bus.op_b  = 16'h2222;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = 16'h9999;
    wait_done();
    chk("idle_hold_result", 32'(bus.result), 32'h1000);
    chk("idle_hold_busy",   32'(bus.busy),   32'd0);

    // Reset two cycles into RUN aborts with no done.
    issue(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   32'(bus.busy),   32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_cout",   32'(bus.cout),   32'd0);
    chk("abort_done",   32'(bus.done),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
    wait_done();

    // Illegal digit A: raw adder output 0xA+0 -> sum 0 carry 1 into digit 2.
    issue(16'h00A5, 16'h0001, 1'b0, 1'b1, 16'h0106, 1'b0, 1'b1);
    chk("invalid_at_start", 32'(bus.invalid), 32'd1);
    wait_done();
    chk("invalid_held_idle", 32'(bus.invalid), 32'd1);
    issue(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
    chk("invalid_cleared", 32'(bus.invalid), 32'd0);
    wait_done();

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
